avst_channel_filter_pipe: RTL

- Parametrised Avalon-ST channel adapter with packet-aware channel suppression and a 2-entry registered skid buffer.
- Sits between a wide-channel source (e.g. byte-to-packet converter) and a narrow-channel sink.
- Drops whole packets whose SOP channel exceeds MAX_CHANNEL, discards orphan beats that arrive outside a packet, breaks the ready timing path, and keeps saturating drop statistics.

---
 rtl/avst_channel_filter_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/avst_channel_filter_pipe.sv
// Avalon-ST channel filter: drops packets whose SOP channel exceeds MAX_CHANNEL,
// discards orphan beats, narrows the channel and buffers the stream in a
// 2-entry registered skid buffer. Keeps saturating drop statistics.
module avst_channel_filter_pipe #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned IN_CHANNEL_W  = 8,
  parameter int unsigned OUT_CHANNEL_W = 1,
  parameter int unsigned MAX_CHANNEL   = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         drop_pkt_count,
  output logic [CNT_W-1:0]         orphan_beat_count
);

  localparam logic [IN_CHANNEL_W-1:0] MaxChan = IN_CHANNEL_W'(MAX_CHANNEL);
  localparam logic [CNT_W-1:0]        CntMax  = {CNT_W{1'b1}};

  // Packet tracking state
  logic in_pkt_q, in_pkt_d;
  logic drop_pkt_q, drop_pkt_d;

  // FIFO head (drives out_*) and second (skid) entry
  logic                     head_valid_q, head_valid_d;
  logic [DATA_W-1:0]        head_data_q, head_data_d;
  logic [OUT_CHANNEL_W-1:0] head_chan_q, head_chan_d;
  logic                     head_sop_q, head_sop_d;
  logic                     head_eop_q, head_eop_d;
  logic                     skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]        skid_data_q, skid_data_d;
  logic [OUT_CHANNEL_W-1:0] skid_chan_q, skid_chan_d;
  logic                     skid_sop_q, skid_sop_d;
  logic                     skid_eop_q, skid_eop_d;

  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] orphan_cnt_q, orphan_cnt_d;

  logic accept, push, pop, drop_inc, orphan_inc;

  // The skid entry is only ever occupied when the head is too, so count<2 == skid empty
  assign in_ready = ~reset & ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = head_valid_q & out_ready;

  // Classify the accepted beat and update packet state
  always_comb begin
    in_pkt_d   = in_pkt_q;
    drop_pkt_d = drop_pkt_q;
    push       = 1'b0;
    drop_inc   = 1'b0;
    orphan_inc = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        // A SOP always starts a new packet, even if the previous one lacked an EOP
        drop_pkt_d = (in_channel > MaxChan);
        in_pkt_d   = ~in_endofpacket;
        drop_inc   = (in_channel > MaxChan);
        push       = ~(in_channel > MaxChan);
      end else if (in_pkt_q) begin
        push = ~drop_pkt_q;
        if (in_endofpacket) in_pkt_d = 1'b0;
      end else begin
        orphan_inc = 1'b1;
      end
    end
  end

  // Two-entry FIFO next state; push with a full FIFO cannot happen since in_ready=0
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_chan_d  = head_chan_q;
    head_sop_d   = head_sop_q;
    head_eop_d   = head_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_chan_d  = skid_chan_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    if (pop && skid_valid_q) begin
      head_valid_d = 1'b1;
      head_data_d  = skid_data_q;
      head_chan_d  = skid_chan_q;
      head_sop_d   = skid_sop_q;
      head_eop_d   = skid_eop_q;
      skid_valid_d = 1'b0;
    end else if (push && (pop || !head_valid_q)) begin
      head_valid_d = 1'b1;
      head_data_d  = in_data;
      head_chan_d  = in_channel[OUT_CHANNEL_W-1:0];
      head_sop_d   = in_startofpacket;
      head_eop_d   = in_endofpacket;
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_chan_d  = in_channel[OUT_CHANNEL_W-1:0];
      skid_sop_d   = in_startofpacket;
      skid_eop_d   = in_endofpacket;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  // Saturating statistics; a clear coinciding with an increment leaves 1
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    orphan_cnt_d = orphan_cnt_q;
    if (clr_stats) begin
      drop_cnt_d   = drop_inc ? CNT_W'(1) : '0;
      orphan_cnt_d = orphan_inc ? CNT_W'(1) : '0;
    end else begin
      if (drop_inc && drop_cnt_q != CntMax)     drop_cnt_d   = drop_cnt_q + CNT_W'(1);
      if (orphan_inc && orphan_cnt_q != CntMax) orphan_cnt_d = orphan_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pkt_q     <= 1'b0;
      drop_pkt_q   <= 1'b0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_chan_q  <= '0;
      head_sop_q   <= 1'b0;
      head_eop_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_chan_q  <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      drop_cnt_q   <= '0;
      orphan_cnt_q <= '0;
    end else begin
      in_pkt_q     <= in_pkt_d;
      drop_pkt_q   <= drop_pkt_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_chan_q  <= head_chan_d;
      head_sop_q   <= head_sop_d;
      head_eop_q   <= head_eop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_chan_q  <= skid_chan_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      drop_cnt_q   <= drop_cnt_d;
      orphan_cnt_q <= orphan_cnt_d;
    end
  end

  assign out_valid         = head_valid_q;
  assign out_data          = head_data_q;
  assign out_channel       = head_chan_q;
  assign out_startofpacket = head_sop_q;
  assign out_endofpacket   = head_eop_q;
  assign drop_pkt_count    = drop_cnt_q;
  assign orphan_beat_count = orphan_cnt_q;

endmodule
